ni_rx_dma: RTL and testbench

Receive-side DMA stage of the tile network interface. Accepts one packet (header flit, size flit, payload flits) from the router local port over a valid/ready handshake and writes it word-by-word into the tile's dual-port RAM through the RAM's B port, starting at a CPU-programmed base address. Sits directly upstream of the tile memory; the CPU owns port A and is told about completion by a one-cycle done pulse plus a latched payload length.

---
 rtl/ni_pkg.sv | 17 +
 rtl/ni_rx_dma.sv | 149 ++++++++++++++
 tb/tb_ni_rx_dma.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ni_pkg.sv
// Shared types and constants for the network-interface receive DMA.
// Word offsets are relative to the CPU-programmed base address.
package ni_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HDR,
    ST_WAIT_SIZE,
    ST_PAYLOAD,
    ST_DONE
  } ni_rx_state_t;

  localparam int HDR_OFFSET     = 0;
  localparam int SIZE_OFFSET    = 1;
  localparam int PAYLOAD_OFFSET = 2;

endpackage

// File: rtl/ni_rx_dma.sv
// Receive-side DMA: accepts header, size and payload flits from the router
// local port and writes them into tile RAM port B at a programmed base.
module ni_rx_dma
  import ni_pkg::*;
#(
  parameter int FLIT_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_PAYLOAD = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_start_in,
  input  logic [ADDR_WIDTH-1:0] cfg_base_in,
  input  logic                  flit_valid_in,
  input  logic [FLIT_WIDTH-1:0] flit_data_in,
  output logic                  flit_ready_out,
  output logic                  mem_enable_out,
  output logic                  mem_wb_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [FLIT_WIDTH-1:0] mem_data_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  overflow_out,
  output logic [FLIT_WIDTH-1:0] rx_len_out
);

  localparam logic [FLIT_WIDTH:0] MaxPay = (FLIT_WIDTH+1)'(MAX_PAYLOAD);

  ni_rx_state_t          state, stateNext;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic [FLIT_WIDTH-1:0] remaining;
  logic [FLIT_WIDTH-1:0] payIdx;

  logic                  payInRange;
  logic                  writeEn;
  logic [ADDR_WIDTH-1:0] writeAddr;
  logic                  loadBase;
  logic                  loadSize;
  logic                  consumePayload;
  logic                  setOverflow;

  assign payInRange = {1'b0, payIdx} < MaxPay;

  // Ready depends only on state, so a transfer is simply valid in a ready state.
  always_comb begin
    stateNext      = state;
    flit_ready_out = 1'b0;
    busy_out       = (state != ST_IDLE);
    done_out       = 1'b0;
    writeEn        = 1'b0;
    writeAddr      = baseAddr;
    loadBase       = 1'b0;
    loadSize       = 1'b0;
    consumePayload = 1'b0;
    setOverflow    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start_in) begin
          loadBase  = 1'b1;
          stateNext = ST_WAIT_HDR;
        end
      end
      ST_WAIT_HDR: begin
        flit_ready_out = 1'b1;
        if (flit_valid_in) begin
          writeEn   = 1'b1;
          writeAddr = baseAddr + ADDR_WIDTH'(HDR_OFFSET);
          stateNext = ST_WAIT_SIZE;
        end
      end
      ST_WAIT_SIZE: begin
        flit_ready_out = 1'b1;
        if (flit_valid_in) begin
          writeEn   = 1'b1;
          writeAddr = baseAddr + ADDR_WIDTH'(SIZE_OFFSET);
          loadSize  = 1'b1;
          stateNext = (flit_data_in == '0) ? ST_DONE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        flit_ready_out = 1'b1;
        if (flit_valid_in) begin
          consumePayload = 1'b1;
          // Words beyond the buffer are still drained from the router but dropped.
          if (payInRange) begin
            writeEn   = 1'b1;
            writeAddr = baseAddr + ADDR_WIDTH'(PAYLOAD_OFFSET) + ADDR_WIDTH'(payIdx);
          end else begin
            setOverflow = 1'b1;
          end
          if (remaining == FLIT_WIDTH'(1)) begin
            stateNext = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_out  = 1'b1;
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      baseAddr       <= '0;
      remaining      <= '0;
      payIdx         <= '0;
      mem_enable_out <= 1'b0;
      mem_wb_out     <= 1'b0;
      mem_addr_out   <= '0;
      mem_data_out   <= '0;
      overflow_out   <= 1'b0;
      rx_len_out     <= '0;
    end else begin
      state          <= stateNext;
      mem_enable_out <= writeEn;
      mem_wb_out     <= writeEn;
      if (writeEn) begin
        mem_addr_out <= writeAddr;
        mem_data_out <= flit_data_in;
      end
      if (loadBase) begin
        baseAddr     <= cfg_base_in;
        overflow_out <= 1'b0;
        rx_len_out   <= '0;
      end
      if (loadSize) begin
        remaining  <= flit_data_in;
        rx_len_out <= flit_data_in;
        payIdx     <= '0;
      end
      // The index saturates once out of range so it can never wrap back into the buffer.
      if (consumePayload) begin
        remaining <= remaining - FLIT_WIDTH'(1);
        if (payInRange) begin
          payIdx <= payIdx + FLIT_WIDTH'(1);
        end
      end
      if (setOverflow) begin
        overflow_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ni_rx_dma.sv
// Self-checking bench for ni_rx_dma: packet table plus a write scoreboard
// keyed on the cycle each RAM strobe is due.
module tb_ni_rx_dma;

  localparam int FW   = 16;
  localparam int AW   = 16;
  localparam int MAXP = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_start_in;
  logic [AW-1:0] cfg_base_in;
  logic          flit_valid_in;
  logic [FW-1:0] flit_data_in;
  logic          flit_ready_out;
  logic          mem_enable_out;
  logic          mem_wb_out;
  logic [AW-1:0] mem_addr_out;
  logic [FW-1:0] mem_data_out;
  logic          busy_out;
  logic          done_out;
  logic          overflow_out;
  logic [FW-1:0] rx_len_out;

  always #5 clock = ~clock;

  ni_rx_dma #(
    .FLIT_WIDTH (FW),
    .ADDR_WIDTH (AW),
    .MAX_PAYLOAD(MAXP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_start_in  (cfg_start_in),
    .cfg_base_in   (cfg_base_in),
    .flit_valid_in (flit_valid_in),
    .flit_data_in  (flit_data_in),
    .flit_ready_out(flit_ready_out),
    .mem_enable_out(mem_enable_out),
    .mem_wb_out    (mem_wb_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_out  (mem_data_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .overflow_out  (overflow_out),
    .rx_len_out    (rx_len_out)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          due;
  } wr_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] hdr;
    logic [15:0] size;
    int          nPay;
    bit          gaps;
    bit          midStart;
    logic [15:0] expLen;
    bit          expOvf;
  } pkt_t;

  wr_t  expQ[$];
  wr_t  headWr;
  pkt_t tbl[6];
  int   nVec      = 0;
  int   nMis      = 0;
  int   cyc       = 0;
  int   expDone   = -1;
  int   doneCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc++;

  // Every strobe must match the head of the scoreboard, including the cycle it was due.
  always @(negedge clock) begin
    if (mem_enable_out || mem_wb_out) begin
      checkOutput("wb_equals_enable", {31'b0, mem_wb_out}, {31'b0, mem_enable_out});
      if (mem_enable_out) begin
        if (expQ.size() == 0) begin
          nVec++;
          nMis++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   mem_addr_out, mem_data_out);
        end else begin
          headWr = expQ.pop_front();
          checkOutput("write_addr", {16'b0, mem_addr_out}, {16'b0, headWr.addr});
          checkOutput("write_data", {16'b0, mem_data_out}, {16'b0, headWr.data});
          checkOutput("write_cycle", cyc, headWr.due);
        end
      end
    end
    if (done_out) begin
      doneCount++;
      checkOutput("done_cycle", cyc, expDone);
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},    {31'b0, flit_ready_out}, 32'd0);
    checkOutput({tag, "_enable"},   {31'b0, mem_enable_out}, 32'd0);
    checkOutput({tag, "_wb"},       {31'b0, mem_wb_out},     32'd0);
    checkOutput({tag, "_addr"},     {16'b0, mem_addr_out},   32'd0);
    checkOutput({tag, "_data"},     {16'b0, mem_data_out},   32'd0);
    checkOutput({tag, "_busy"},     {31'b0, busy_out},       32'd0);
    checkOutput({tag, "_done"},     {31'b0, done_out},       32'd0);
    checkOutput({tag, "_overflow"}, {31'b0, overflow_out},   32'd0);
    checkOutput({tag, "_rx_len"},   {16'b0, rx_len_out},     32'd0);
  endtask

  // Streams one packet; expected writes go on the scoreboard as each flit is offered.
  task automatic applyStimulus(input pkt_t p);
    int          total;
    int          startDone;
    logic [15:0] data;
    wr_t         w;
    total = 2 + p.nPay;
    cfg_start_in = 1'b1;
    cfg_base_in  = p.base;
    stepCycle();
    cfg_start_in = 1'b0;
    cfg_base_in  = 16'h0000;
    checkOutput("busy_after_start",     {31'b0, busy_out},       32'd1);
    checkOutput("ready_after_start",    {31'b0, flit_ready_out}, 32'd1);
    checkOutput("overflow_after_start", {31'b0, overflow_out},   32'd0);
    checkOutput("rx_len_after_start",   {16'b0, rx_len_out},     32'd0);
    startDone = doneCount;
    for (int i = 0; i < total; i++) begin
      if (p.gaps && i > 0) begin
        flit_valid_in = 1'b0;
        flit_data_in  = 16'hDEAD;
        stepCycle();
      end
      data = (i == 0) ? p.hdr : (i == 1) ? p.size : 16'h00A0 + 16'(i - 2);
      flit_valid_in = 1'b1;
      flit_data_in  = data;
      if (p.midStart && i == 0) begin
        cfg_start_in = 1'b1;
        cfg_base_in  = 16'h0400;
      end
      checkOutput("ready_in_packet", {31'b0, flit_ready_out}, 32'd1);
      if (i < 2 + MAXP) begin
        w.addr = p.base + 16'(i);
        w.data = data;
        w.due  = cyc + 1;
        expQ.push_back(w);
      end
      if (i == total - 1) expDone = cyc + 1;
      stepCycle();
      cfg_start_in = 1'b0;
      cfg_base_in  = 16'h0000;
    end
    flit_valid_in = 1'b0;
    checkOutput("done_pulse",   {31'b0, done_out},       32'd1);
    checkOutput("busy_in_done", {31'b0, busy_out},       32'd1);
    checkOutput("ready_in_done",{31'b0, flit_ready_out}, 32'd0);
    stepCycle();
    checkOutput("done_cleared", {31'b0, done_out},     32'd0);
    checkOutput("busy_cleared", {31'b0, busy_out},     32'd0);
    checkOutput("rx_len",       {16'b0, rx_len_out},   {16'b0, p.expLen});
    checkOutput("overflow",     {31'b0, overflow_out}, {31'b0, p.expOvf});
    checkOutput("done_count",   doneCount - startDone, 32'd1);
    checkOutput("writes_drained", expQ.size(), 32'd0);
  endtask

  initial begin
    wr_t w;
    int  doneBefore;
    tbl[0] = '{16'h0100, 16'h0011, 16'h0003, 3, 1'b0, 1'b0, 16'h0003, 1'b0};
    tbl[1] = '{16'h0100, 16'h0011, 16'h0003, 3, 1'b1, 1'b0, 16'h0003, 1'b0};
    tbl[2] = '{16'h0100, 16'h0011, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[3] = '{16'h0100, 16'h0044, 16'h0006, 6, 1'b0, 1'b0, 16'h0006, 1'b1};
    tbl[4] = '{16'hFFFE, 16'h0055, 16'h0002, 2, 1'b0, 1'b0, 16'h0002, 1'b0};
    tbl[5] = '{16'h0300, 16'h0066, 16'h0001, 1, 1'b0, 1'b1, 16'h0001, 1'b0};

    reset         = 1'b1;
    cfg_start_in  = 1'b0;
    cfg_base_in   = 16'h0000;
    flit_valid_in = 1'b0;
    flit_data_in  = 16'h0000;
    stepCycle();
    stepCycle();
    checkResetValues("reset");
    reset = 1'b0;
    stepCycle();

    for (int k = 0; k < 6; k++) begin
      applyStimulus(tbl[k]);
      stepCycle();
    end

    // Reset in the middle of a packet abandons it; only already-transferred words land.
    doneBefore   = doneCount;
    cfg_start_in = 1'b1;
    cfg_base_in  = 16'h0200;
    stepCycle();
    cfg_start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flit_valid_in = 1'b1;
      flit_data_in  = (i == 0) ? 16'h0022 : (i == 1) ? 16'h0004 : 16'h00B0 + 16'(i - 2);
      w.addr = 16'h0200 + 16'(i);
      w.data = flit_data_in;
      w.due  = cyc + 1;
      expQ.push_back(w);
      stepCycle();
    end
    reset        = 1'b1;
    flit_data_in = 16'h00B2;
    stepCycle();
    checkResetValues("midreset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("ready_idle_after_reset", {31'b0, flit_ready_out}, 32'd0);
      checkOutput("busy_idle_after_reset",  {31'b0, busy_out},       32'd0);
    end
    flit_valid_in = 1'b0;
    stepCycle();
    checkOutput("midreset_writes_drained", expQ.size(), 32'd0);
    checkOutput("midreset_no_done", doneCount - doneBefore, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
